router_ctrl: RTL and testbench
==============================

ROUTER_CTRL -- requirements
Module: router_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 30, meaning idle-read cycles before a FIFO soft reset.
REQ-002 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port pkt_valid  input  1  source packet in progress.
REQ-005 SHALL have port data_in  input  2  header address bits [1:0]; 0/1/2 valid, 3 invalid.
REQ-006 SHALL have port fifo_full_in  input  3  full flags of FIFO 2..0.
REQ-007 SHALL have port fifo_empty_in  input  3  empty flags of FIFO 2..0.
REQ-008 SHALL have port read_enb  input  3  destination read enables 2..0.
REQ-009 SHALL have port parity_done  input  1  parity byte already written.
REQ-010 SHALL have port low_pkt_valid  input  1  pkt_valid fell while FIFO full.
REQ-011 SHALL have port write_enb  output  3  one-hot FIFO write enable.
REQ-012 SHALL have port soft_reset  output  3  per-FIFO soft reset pulses.
REQ-013 SHALL have ports detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, busy, write_enb_reg, fifo_full  output  1 each  state decodes and selected full flag.

Function
REQ-014 SHALL implement Moore FSM states DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, LOAD_PARITY, FIFO_FULL_STATE, LOAD_AFTER_FULL, WAIT_TILL_EMPTY, CHECK_PARITY_ERROR.
REQ-015 SHALL, in DECODE_ADDRESS with pkt_valid and data_in!=3, latch addr=data_in and go to LOAD_FIRST_DATA if fifo_empty_in[data_in] else WAIT_TILL_EMPTY; data_in==3 or !pkt_valid: stay.
REQ-016 SHALL go LOAD_FIRST_DATA -> LOAD_DATA unconditionally.
REQ-017 SHALL, in LOAD_DATA: fifo_full -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay (fifo_full has priority).
REQ-018 SHALL go FIFO_FULL_STATE -> LOAD_AFTER_FULL when !fifo_full, else stay.
REQ-019 SHALL, in LOAD_AFTER_FULL: parity_done -> DECODE_ADDRESS; else low_pkt_valid -> LOAD_PARITY; else LOAD_DATA.
REQ-020 SHALL go LOAD_PARITY -> CHECK_PARITY_ERROR; CHECK_PARITY_ERROR -> FIFO_FULL_STATE if fifo_full else DECODE_ADDRESS.
REQ-021 SHALL go WAIT_TILL_EMPTY -> LOAD_FIRST_DATA when fifo_empty_in[addr], else stay.
REQ-022 SHALL drive fifo_full = fifo_full_in[addr] combinationally.
REQ-023 SHALL decode: detect_add=DECODE_ADDRESS, lfd_state=LOAD_FIRST_DATA, ld_state=LOAD_DATA, laf_state=LOAD_AFTER_FULL, full_state=FIFO_FULL_STATE, rst_int_reg=CHECK_PARITY_ERROR.
REQ-024 SHALL assert write_enb_reg in LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL; busy in every state except DECODE_ADDRESS and LOAD_DATA.
REQ-025 SHALL drive write_enb = (1<<addr) when write_enb_reg, else 3'b000; never more than one bit set.
REQ-026 SHALL, when soft_reset[addr] asserts in any non-DECODE state, go to DECODE_ADDRESS next cycle (overrides all other transitions).

Reset
REQ-027 SHALL, on resetn low, asynchronously set state=DECODE_ADDRESS, addr=0, all timers=0, soft_reset=0; outputs then: detect_add=1, write_enb=0, busy=0.
REQ-028 SHALL abandon an in-flight packet on reset with no residual write_enb.

Configuration
REQ-029 SHALL, with ROUTER_SOFT_RESET_TIMER_EN defined, keep per-FIFO counter n: clear when fifo_empty_in[n] or read_enb[n]; else increment; at TIMEOUT-1 pulse soft_reset[n] one cycle and clear counter.
REQ-030 SHALL, without ROUTER_SOFT_RESET_TIMER_EN, tie soft_reset to 3'b000, instantiate no counters, REQ-026 never fires.

Verification
REQ-031 SHALL cover: reset, pkt_valid=1, data_in=1, fifo_empty_in=3'b111 -> LOAD_FIRST_DATA next cycle, write_enb=3'b010 during LOAD_DATA.
REQ-032 SHALL cover: data_in=3 with pkt_valid=1 for 5 cycles -> detect_add stays 1, write_enb=0.
REQ-033 SHALL cover: addr 0, fifo_full_in[0]=1 in LOAD_DATA -> FIFO_FULL_STATE, busy=1, write_enb=0; full cleared, low_pkt_valid=1 -> LOAD_AFTER_FULL then LOAD_PARITY.
REQ-034 SHALL cover: data_in=2, fifo_empty_in[2]=0 -> WAIT_TILL_EMPTY; empty asserted cycle 7 -> LOAD_FIRST_DATA cycle 8.
REQ-035 SHALL cover (macro on): fifo_empty_in[1]=0, read_enb[1]=0 for 30 cycles -> soft_reset[1] single pulse on 30th cycle; read_enb[1]=1 at cycle 20 -> no pulse.
REQ-036 SHALL cover: resetn low mid LOAD_DATA -> same-cycle detect_add=1, write_enb=0.

Source files
------------

// File: rtl/router_ctrl.sv
// router_ctrl -- packet router control FSM.
// Decodes the destination address from the header, steers one-hot FIFO write
// enables, handles full/after-full/parity sequencing and waits for an empty
// destination FIFO before loading a new packet.
// Optional feature: define ROUTER_SOFT_RESET_TIMER_EN to build per-FIFO idle
// timers that soft-reset a FIFO nobody has read for TIMEOUT cycles. Without
// the macro soft_reset is tied low and no timers exist.
module router_ctrl #(
  parameter int TIMEOUT = 30
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic [2:0] fifo_full_in,
  input  logic [2:0] fifo_empty_in,
  input  logic [2:0] read_enb,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic [2:0] write_enb,
  output logic [2:0] soft_reset,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       busy,
  output logic       write_enb_reg,
  output logic       fifo_full
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    LOAD_PARITY,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    WAIT_TILL_EMPTY,
    CHECK_PARITY_ERROR
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] addr;
  logic [1:0] addr_nxt;

  // Per-FIFO flags selected by the latched address (addr never holds 3)
  logic       sel_full;
  logic       sel_empty;
  logic       sel_srst;
  // Empty flag of the FIFO named by the incoming header
  logic       hdr_empty;

`ifdef ROUTER_SOFT_RESET_TIMER_EN
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT + 1) : 2;

  logic [CNT_W-1:0] idle_cnt [3];

  // Idle-read timers: restart on empty or read, pulse soft_reset at TIMEOUT-1
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      soft_reset <= 3'b000;
      for (int n = 0; n < 3; n++) begin
        idle_cnt[n] <= '0;
      end
    end else begin
      for (int n = 0; n < 3; n++) begin
        if (fifo_empty_in[n] || read_enb[n]) begin
          idle_cnt[n]   <= '0;
          soft_reset[n] <= 1'b0;
        end else if (idle_cnt[n] == CNT_W'(TIMEOUT - 1)) begin
          idle_cnt[n]   <= '0;
          soft_reset[n] <= 1'b1;
        end else begin
          idle_cnt[n]   <= idle_cnt[n] + 1'b1;
          soft_reset[n] <= 1'b0;
        end
      end
    end
  end
`else
  // Timers not built: read enables and TIMEOUT have no consumer
  logic unused_timer_inputs;

  assign soft_reset          = 3'b000;
  assign unused_timer_inputs = ^{read_enb, TIMEOUT[0]};
`endif

  // Select the full/empty/soft-reset flags of the latched destination
  always_comb begin
    sel_full  = 1'b0;
    sel_empty = 1'b0;
    sel_srst  = 1'b0;
    case (addr)
      2'd0: begin
        sel_full  = fifo_full_in[0];
        sel_empty = fifo_empty_in[0];
        sel_srst  = soft_reset[0];
      end
      2'd1: begin
        sel_full  = fifo_full_in[1];
        sel_empty = fifo_empty_in[1];
        sel_srst  = soft_reset[1];
      end
      2'd2: begin
        sel_full  = fifo_full_in[2];
        sel_empty = fifo_empty_in[2];
        sel_srst  = soft_reset[2];
      end
      default: begin
        sel_full  = 1'b0;
        sel_empty = 1'b0;
        sel_srst  = 1'b0;
      end
    endcase
  end

  // Select the empty flag of the FIFO addressed by the header byte
  always_comb begin
    hdr_empty = 1'b0;
    case (data_in)
      2'd0:    hdr_empty = fifo_empty_in[0];
      2'd1:    hdr_empty = fifo_empty_in[1];
      2'd2:    hdr_empty = fifo_empty_in[2];
      default: hdr_empty = 1'b0;
    endcase
  end

  assign fifo_full = sel_full;

  // State and destination address registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= DECODE_ADDRESS;
      addr  <= 2'd0;
    end else begin
      state <= state_nxt;
      addr  <= addr_nxt;
    end
  end

  // Next-state logic; a soft reset of the active FIFO abandons the packet
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    case (state)
      DECODE_ADDRESS: begin
        if (pkt_valid && (data_in != 2'd3)) begin
          addr_nxt  = data_in;
          state_nxt = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: state_nxt = LOAD_DATA;
      LOAD_DATA: begin
        if (sel_full) begin
          state_nxt = FIFO_FULL_STATE;
        end else if (!pkt_valid) begin
          state_nxt = LOAD_PARITY;
        end
      end
      LOAD_PARITY: state_nxt = CHECK_PARITY_ERROR;
      FIFO_FULL_STATE: begin
        if (!sel_full) begin
          state_nxt = LOAD_AFTER_FULL;
        end
      end
      LOAD_AFTER_FULL: begin
        if (parity_done) begin
          state_nxt = DECODE_ADDRESS;
        end else if (low_pkt_valid) begin
          state_nxt = LOAD_PARITY;
        end else begin
          state_nxt = LOAD_DATA;
        end
      end
      WAIT_TILL_EMPTY: begin
        if (sel_empty) begin
          state_nxt = LOAD_FIRST_DATA;
        end
      end
      CHECK_PARITY_ERROR: begin
        state_nxt = sel_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end
      default: state_nxt = DECODE_ADDRESS;
    endcase
    if (sel_srst && (state != DECODE_ADDRESS)) begin
      state_nxt = DECODE_ADDRESS;
    end
  end

  // Moore state decodes
  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    rst_int_reg   = 1'b0;
    write_enb_reg = 1'b0;
    busy          = 1'b1;
    case (state)
      DECODE_ADDRESS: begin
        detect_add = 1'b1;
        busy       = 1'b0;
      end
      LOAD_FIRST_DATA: lfd_state = 1'b1;
      LOAD_DATA: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
        busy          = 1'b0;
      end
      LOAD_PARITY: write_enb_reg = 1'b1;
      FIFO_FULL_STATE: full_state = 1'b1;
      LOAD_AFTER_FULL: begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
      end
      CHECK_PARITY_ERROR: rst_int_reg = 1'b1;
      default: busy = 1'b1;
    endcase
  end

  // One-hot write enable toward the latched destination FIFO
  always_comb begin
    write_enb = 3'b000;
    if (write_enb_reg) begin
      case (addr)
        2'd0:    write_enb = 3'b001;
        2'd1:    write_enb = 3'b010;
        2'd2:    write_enb = 3'b100;
        default: write_enb = 3'b000;
      endcase
    end
  end

endmodule

// File: tb/tb_router_ctrl.sv
// tb_router_ctrl -- self-checking bench for router_ctrl.
// Directed scenarios followed by randomized traffic, compared every cycle
// against a behavioural model built from named packet phases.
module tb_router_ctrl;

  localparam int TIMEOUT = 30;

  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic       pkt_valid = 1'b0;
  logic [1:0] data_in = 2'd0;
  logic [2:0] fifo_full_in = 3'b000;
  logic [2:0] fifo_empty_in = 3'b111;
  logic [2:0] read_enb = 3'b000;
  logic       parity_done = 1'b0;
  logic       low_pkt_valid = 1'b0;
  logic [2:0] write_enb;
  logic [2:0] soft_reset;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       rst_int_reg, busy, write_enb_reg, fifo_full;

  int n_asrt = 0;
  int n_fail = 0;

  // Reference model: phase name, destination, soft-reset pulses, idle counts
  string      mst;
  int         maddr;
  logic [2:0] msr;
  int         mcnt [3];

  router_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full_in(fifo_full_in), .fifo_empty_in(fifo_empty_in), .read_enb(read_enb),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .write_enb(write_enb), .soft_reset(soft_reset), .detect_add(detect_add),
    .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
    .full_state(full_state), .rst_int_reg(rst_int_reg), .busy(busy),
    .write_enb_reg(write_enb_reg), .fifo_full(fifo_full)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mst   = "DA";
    maddr = 0;
    msr   = 3'b000;
    for (int n = 0; n < 3; n++) mcnt[n] = 0;
  endtask

  task automatic check_outputs();
    logic       wr;
    logic [2:0] exp_we;
    wr     = (mst == "LD") || (mst == "LP") || (mst == "LAF");
    exp_we = wr ? 3'(1 << maddr) : 3'b000;
    chk("detect_add",    8'(detect_add),    8'(mst == "DA"));
    chk("lfd_state",     8'(lfd_state),     8'(mst == "LFD"));
    chk("ld_state",      8'(ld_state),      8'(mst == "LD"));
    chk("laf_state",     8'(laf_state),     8'(mst == "LAF"));
    chk("full_state",    8'(full_state),    8'(mst == "FFS"));
    chk("rst_int_reg",   8'(rst_int_reg),   8'(mst == "CPE"));
    chk("busy",          8'(busy),          8'(!((mst == "DA") || (mst == "LD"))));
    chk("write_enb_reg", 8'(write_enb_reg), 8'(wr));
    chk("write_enb",     8'(write_enb),     8'(exp_we));
    chk("fifo_full",     8'(fifo_full),     8'(fifo_full_in[maddr]));
    chk("soft_reset",    8'(soft_reset),    8'(msr));
    chk("we_onehot",     8'($countones(write_enb) <= 1), 8'd1);
  endtask

  // One clock: check current outputs, advance the model, cross the edge
  task automatic tick();
    string      nst;
    int         naddr;
    logic [2:0] nsr;
    #1;
    check_outputs();
    nst   = mst;
    naddr = maddr;
    if (mst == "DA") begin
      if (pkt_valid && data_in != 2'd3) begin
        naddr = int'(data_in);
        nst   = fifo_empty_in[data_in] ? "LFD" : "WTE";
      end
    end else if (mst == "LFD") nst = "LD";
    else if (mst == "LD") begin
      if (fifo_full_in[maddr]) nst = "FFS";
      else if (!pkt_valid) nst = "LP";
    end else if (mst == "FFS") begin
      if (!fifo_full_in[maddr]) nst = "LAF";
    end else if (mst == "LAF") begin
      nst = parity_done ? "DA" : (low_pkt_valid ? "LP" : "LD");
    end else if (mst == "LP") nst = "CPE";
    else if (mst == "CPE") nst = fifo_full_in[maddr] ? "FFS" : "DA";
    else if (mst == "WTE") begin
      if (fifo_empty_in[maddr]) nst = "LFD";
    end
    if (msr[maddr] && mst != "DA") nst = "DA";
    nsr = 3'b000;
`ifdef ROUTER_SOFT_RESET_TIMER_EN
    for (int n = 0; n < 3; n++) begin
      if (fifo_empty_in[n] || read_enb[n]) mcnt[n] = 0;
      else if (mcnt[n] == TIMEOUT - 1) begin
        nsr[n]  = 1'b1;
        mcnt[n] = 0;
      end else mcnt[n]++;
    end
`endif
    @(posedge clock);
    mst   = nst;
    maddr = naddr;
    msr   = nsr;
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    pkt_valid     = 1'b0;
    data_in       = 2'd0;
    fifo_full_in  = 3'b000;
    fifo_empty_in = 3'b111;
    read_enb      = 3'b000;
    parity_done   = 1'b0;
    low_pkt_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    #2 resetn = 1'b0;
    #1;
    check_outputs();
    chk("rst_detect_add", 8'(detect_add), 8'd1);
    chk("rst_write_enb",  8'(write_enb),  8'd0);
    chk("rst_busy",       8'(busy),       8'd0);
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;

    // Header to FIFO 1, all FIFOs empty
    pkt_valid = 1'b1; data_in = 2'd1;
    tick();
    chk("hdr1_lfd", 8'(lfd_state), 8'd1);
    tick();
    chk("hdr1_ld", 8'(ld_state), 8'd1);
    chk("hdr1_we", 8'(write_enb), 8'b010);
    pkt_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("hdr1_back", 8'(detect_add), 8'd1);

    // Invalid address held for five cycles
    pkt_valid = 1'b1; data_in = 2'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("addr3_detect", 8'(detect_add), 8'd1);
      chk("addr3_we",     8'(write_enb),  8'd0);
    end

    // FIFO 0 fills during LOAD_DATA
    idle_inputs();
    pkt_valid = 1'b1; data_in = 2'd0;
    tick();
    tick();
    chk("full_ld_we", 8'(write_enb), 8'b001);
    fifo_full_in = 3'b001;
    tick();
    chk("full_state", 8'(full_state), 8'd1);
    chk("full_busy",  8'(busy),       8'd1);
    chk("full_we",    8'(write_enb),  8'd0);
    tick();
    chk("full_hold", 8'(full_state), 8'd1);
    fifo_full_in = 3'b000; low_pkt_valid = 1'b1; pkt_valid = 1'b0;
    tick();
    chk("laf_state", 8'(laf_state), 8'd1);
    tick();
    chk("lp_we",   8'(write_enb),     8'b001);
    chk("lp_wreg", 8'(write_enb_reg), 8'd1);
    low_pkt_valid = 1'b0;
    tick();
    chk("cpe", 8'(rst_int_reg), 8'd1);
    tick();

    // FIFO 2 not empty: wait, becomes empty at cycle 7
    pkt_valid = 1'b1; data_in = 2'd2; fifo_empty_in = 3'b011;
    tick();
    pkt_valid = 1'b0;
    for (int c = 2; c <= 7; c++) begin
      chk("wte_busy", 8'(busy), 8'd1);
      chk("wte_lfd",  8'(lfd_state), 8'd0);
      if (c == 7) fifo_empty_in = 3'b111;
      tick();
    end
    chk("wte_to_lfd", 8'(lfd_state), 8'd1);
    tick();

    // Reset in the middle of LOAD_DATA
    chk("pre_rst_ld", 8'(ld_state), 8'd1);
    #2 resetn = 1'b0;
    #1;
    chk("midrst_detect", 8'(detect_add), 8'd1);
    chk("midrst_we",     8'(write_enb),  8'd0);
    model_reset();
    idle_inputs();
    @(negedge clock);
    check_outputs();
    resetn = 1'b1;
    tick();

`ifdef ROUTER_SOFT_RESET_TIMER_EN
    // FIFO 1 idle for TIMEOUT cycles
    fifo_empty_in = 3'b101;
    for (int c = 1; c <= TIMEOUT; c++) begin
      tick();
      chk("sr_pulse", 8'(soft_reset), (c == TIMEOUT) ? 8'b010 : 8'b000);
    end
    fifo_empty_in = 3'b111;
    tick();
    chk("sr_single", 8'(soft_reset), 8'd0);
    // Read at cycle 20 restarts the timer
    fifo_empty_in = 3'b101;
    for (int c = 1; c <= 35; c++) begin
      read_enb = (c == 20) ? 3'b010 : 3'b000;
      tick();
      chk("sr_nopulse", 8'(soft_reset), 8'd0);
    end
    // Soft reset of the waited-for FIFO abandons WAIT_TILL_EMPTY
    idle_inputs();
    tick();
    pkt_valid = 1'b1; data_in = 2'd1; fifo_empty_in = 3'b101;
    tick();
    pkt_valid = 1'b0;
    for (int c = 2; c <= 31; c++) tick();
    chk("sr_abort", 8'(detect_add), 8'd1);
    idle_inputs();
    tick();
`endif

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      pkt_valid     = ($urandom_range(0, 3) != 0);
      data_in       = 2'($urandom_range(0, 3));
      fifo_empty_in = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 3) != 0)};
      fifo_full_in  = {($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                       ($urandom_range(0, 4) == 0)};
      read_enb      = 3'($urandom_range(0, 7));
      parity_done   = ($urandom_range(0, 3) == 0);
      low_pkt_valid = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) == 0) begin
        #2 resetn = 1'b0;
        #1;
        chk("rnd_rst_we", 8'(write_enb), 8'd0);
        model_reset();
        @(negedge clock);
        resetn = 1'b1;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
